// File: rtl/batcharger_ctrl_fsm.sv
// Charge-mode controller for the BATCHARGER Li-Po charger: selects trickle/CC/CV/end
// mode from ADC codes and drives the analog core's mode and measurement enables.
module batcharger_ctrl_fsm #(
    parameter int ADCW  = 8,
    parameter int TW    = 16,
    parameter int PRESC = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            vtok,
    input  logic [ADCW-1:0] vbat,
    input  logic [ADCW-1:0] ibat,
    input  logic [ADCW-1:0] vtbat,
    input  logic [ADCW-1:0] vcutoff,
    input  logic [ADCW-1:0] vpreset,
    input  logic [ADCW-1:0] vrecharge,
    input  logic [ADCW-1:0] iend,
    input  logic [ADCW-1:0] tempmin,
    input  logic [ADCW-1:0] tempmax,
    input  logic [TW-1:0]   tmax,
    output logic            tc,
    output logic            cc,
    output logic            cv,
    output logic            imeasen,
    output logic            vmeasen,
    output logic            tmeasen,
    output logic [2:0]      state,
    output logic [TW-1:0]   charge_time
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_TC   = 3'b001,
        S_CC   = 3'b010,
        S_CV   = 3'b011,
        S_END  = 3'b100
    } state_t;

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    state_t          r_state;
    logic [5:0]      r_outs;
    logic [TW-1:0]   r_charge_time;
    logic [PW-1:0]   r_presc;

    logic            w_ok;
    logic            w_presc_wrap;
    logic            w_ct_sat;
    state_t          w_next_state;

    // Output pattern {tc, cc, cv, imeasen, vmeasen, tmeasen} for each state.
    function automatic logic [5:0] outs_of(input state_t s);
        case (s)
            S_TC:    outs_of = 6'b100011;
            S_CC:    outs_of = 6'b010011;
            S_CV:    outs_of = 6'b001101;
            S_END:   outs_of = 6'b000010;
            default: outs_of = 6'b000011;
        endcase
    endfunction

    assign w_ok         = en & vtok & (vtbat >= tempmin) & (vtbat <= tempmax);
    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_ct_sat     = &r_charge_time;

    // Loss of ok dominates every other arc; illegal codes fall back to IDLE.
    always_comb begin
        w_next_state = S_IDLE;
        if (w_ok) begin
            case (r_state)
                S_IDLE: begin
                    if (vbat < vcutoff)
                        w_next_state = S_TC;
                    else if (vbat < vrecharge)
                        w_next_state = S_CC;
                    else
                        w_next_state = S_END;
                end
                S_TC:    w_next_state = (vbat >= vcutoff) ? S_CC : S_TC;
                S_CC:    w_next_state = (vbat >= vpreset) ? S_CV : S_CC;
                S_CV:    w_next_state = ((ibat < iend) || (r_charge_time >= tmax)) ? S_END : S_CV;
                S_END:   w_next_state = (vbat < vrecharge) ? S_IDLE : S_END;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_outs        <= outs_of(S_IDLE);
            r_charge_time <= '0;
            r_presc       <= '0;
        end else begin
            r_state <= w_next_state;
            r_outs  <= outs_of(w_next_state);
            // The CV timer runs only while in CV, so it reads 0 on the first CV cycle.
            if (r_state == S_CV) begin
                if (w_presc_wrap) begin
                    r_presc <= '0;
                    if (!w_ct_sat)
                        r_charge_time <= r_charge_time + TW'(1);
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end else begin
                r_presc       <= '0;
                r_charge_time <= '0;
            end
        end
    end

    assign {tc, cc, cv, imeasen, vmeasen, tmeasen} = r_outs;
    assign state       = r_state;
    assign charge_time = r_charge_time;

endmodule
